// File: rtl/alu_exec_stage_if.sv
// Bundled request, ALU and result buses of the ALU execute stage.
// The slave modport is the stage's view; the master modport is its environment's view.
interface alu_exec_stage_if #(
  parameter int BITS     = 8,
  parameter int CNT_BITS = 16
);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [BITS-1:0]     req_a_i;
  logic [BITS-1:0]     req_b_i;
  logic [1:0]          req_op_i;
  logic [BITS-1:0]     alu_a_o;
  logic [BITS-1:0]     alu_b_o;
  logic [1:0]          alu_ctrl_o;
  logic [BITS-1:0]     alu_s_i;
  logic [3:0]          alu_flags_i;
  logic                res_valid_o;
  logic                res_ready_i;
  logic [BITS-1:0]     res_o;
  logic [3:0]          res_flags_o;
  logic [CNT_BITS-1:0] op_count_o;
  logic                ovf_sticky_o;
  logic                clr_sticky_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_op_i, alu_s_i, alu_flags_i,
           res_ready_i, clr_sticky_i,
    output req_ready_o, alu_a_o, alu_b_o, alu_ctrl_o, res_valid_o, res_o,
           res_flags_o, op_count_o, ovf_sticky_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_op_i, alu_s_i, alu_flags_i,
           res_ready_i, clr_sticky_i,
    input  req_ready_o, alu_a_o, alu_b_o, alu_ctrl_o, res_valid_o, res_o,
           res_flags_o, op_count_o, ovf_sticky_o
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Two-deep execute stage around a combinational ALU: issue register, result register,
// saturating consume counter and sticky overflow. ALU_EXEC_ZERO_FLAG_EN recomputes flag[0] as zero.
module alu_exec_stage #(
  parameter int BITS     = 8,
  parameter int CNT_BITS = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  alu_exec_stage_if.slave bus
);

  logic                s1_valid_q, s1_valid_d;
  logic [BITS-1:0]     s1_a_q, s1_a_d;
  logic [BITS-1:0]     s1_b_q, s1_b_d;
  logic [1:0]          s1_op_q, s1_op_d;
  logic                res_valid_q, res_valid_d;
  logic [BITS-1:0]     res_q, res_d;
  logic [3:0]          flags_q, flags_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                sticky_q, sticky_d;

  logic s2_free, s1_adv, req_ready, accept, consume;
  logic [3:0] flags_in;

  always_comb begin
    s2_free   = !res_valid_q || bus.res_ready_i;
    s1_adv    = s1_valid_q && s2_free;
    // Ready looks through a draining result register, so a full pipe still streams.
    req_ready = !s1_valid_q || s1_adv;
    accept    = bus.req_valid_i && req_ready;
    consume   = res_valid_q && bus.res_ready_i;
  end

  always_comb begin
    flags_in = bus.alu_flags_i;
`ifdef ALU_EXEC_ZERO_FLAG_EN
    flags_in[0] = (bus.alu_s_i == '0);
`endif
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = bus.req_a_i;
      s1_b_d     = bus.req_b_i;
      s1_op_d    = bus.req_op_i;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      res_valid_d = 1'b1;
      res_d       = bus.alu_s_i;
      flags_d     = flags_in;
    end else if (bus.res_ready_i) begin
      res_valid_d = 1'b0;
    end

    if (consume && (cnt_q != '1)) cnt_d = cnt_q + CNT_BITS'(1);

    // Set is tested first so a coincident clear loses.
    if (consume && flags_q[1]) sticky_d = 1'b1;
    else if (bus.clr_sticky_i) sticky_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.alu_a_o      = s1_a_q;
  assign bus.alu_b_o      = s1_b_q;
  assign bus.alu_ctrl_o   = s1_op_q;
  assign bus.res_valid_o  = res_valid_q;
  assign bus.res_o        = res_q;
  assign bus.res_flags_o  = flags_q;
  assign bus.op_count_o   = cnt_q;
  assign bus.ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural 8-bit ALU on the ALU bus.
// Counter width is 4 so saturation is reachable in a short run.
module tb_alu_exec_stage;

  localparam int BITS     = 8;
  localparam int CNT_BITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_drive = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_exec_stage_if #(.BITS(BITS), .CNT_BITS(CNT_BITS)) bus ();

  alu_exec_stage #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Reference ALU: flags = {C, N, V, O}; O follows o_drive so pass-through is observable.
  logic [8:0] wide;
  logic       v;
  always_comb begin
    wide = 9'd0;
    v    = 1'b0;
    case (bus.alu_ctrl_o)
      2'd0: begin
        wide = {1'b0, bus.alu_a_o} + {1'b0, bus.alu_b_o};
        v    = (bus.alu_a_o[7] == bus.alu_b_o[7]) && (wide[7] != bus.alu_a_o[7]);
      end
      2'd1: begin
        wide = {1'b0, bus.alu_a_o} - {1'b0, bus.alu_b_o};
        v    = (bus.alu_a_o[7] != bus.alu_b_o[7]) && (wide[7] != bus.alu_a_o[7]);
      end
      2'd2: wide = {1'b0, bus.alu_a_o << bus.alu_b_o};
      default: wide = {1'b0, bus.alu_a_o >> bus.alu_b_o};
    endcase
    bus.alu_s_i     = wide[7:0];
    bus.alu_flags_i = {wide[8], wide[7], v, o_drive};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bus.req_valid_i = 1'b1;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_op_i    = op;
  endtask

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.req_op_i     = '0;
    bus.res_ready_i  = 1'b1;
    bus.clr_sticky_i = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_res_valid", bus.res_valid_o, 0);
    check("rst_req_ready", bus.req_ready_o, 1);
    check("rst_res", bus.res_o, 0);
    check("rst_flags", bus.res_flags_o, 0);
    check("rst_alu_a", bus.alu_a_o, 0);
    check("rst_count", bus.op_count_o, 0);
    check("rst_sticky", bus.ovf_sticky_o, 0);

    // Streaming at one op per cycle
    req(8'h03, 8'h04, 2'd0);
    tick();
    check("stream_alu_a", bus.alu_a_o, 8'h03);
    check("stream_alu_b", bus.alu_b_o, 8'h04);
    check("stream_alu_ctrl", bus.alu_ctrl_o, 0);
    check("stream_res_valid0", bus.res_valid_o, 0);
    req(8'h10, 8'h01, 2'd1);
    tick();
    check("stream_res_add", bus.res_o, 8'h07);
    check("stream_valid_add", bus.res_valid_o, 1);
    check("stream_flags_add", bus.res_flags_o, 4'b0000);
    req(8'h01, 8'h02, 2'd2);
    tick();
    check("stream_res_sub", bus.res_o, 8'h0F);
    bus.req_valid_i = 1'b0;
    tick();
    check("stream_res_shl", bus.res_o, 8'h04);
    tick();
    check("stream_drained", bus.res_valid_o, 0);
    check("stream_count", bus.op_count_o, 3);

    // Backpressure: two ops in flight, third refused
    bus.res_ready_i = 1'b0;
    req(8'h01, 8'h01, 2'd0);
    check("bp_ready1", bus.req_ready_o, 1);
    tick();
    req(8'h02, 8'h02, 2'd0);
    check("bp_ready2", bus.req_ready_o, 1);
    tick();
    req(8'h03, 8'h03, 2'd0);
    check("bp_ready3", bus.req_ready_o, 0);
    check("bp_res_first", bus.res_o, 8'h02);
    tick();
    check("bp_hold_res", bus.res_o, 8'h02);
    check("bp_hold_ready", bus.req_ready_o, 0);
    check("bp_hold_alu_a", bus.alu_a_o, 8'h02);
    tick();
    check("bp_hold_res2", bus.res_o, 8'h02);
    check("bp_hold_valid", bus.res_valid_o, 1);
    bus.res_ready_i = 1'b1;
    #1;
    check("bp_ready_comb", bus.req_ready_o, 1);
    tick();
    bus.req_valid_i = 1'b0;
    check("bp_drain2", bus.res_o, 8'h04);
    tick();
    check("bp_drain3", bus.res_o, 8'h06);
    check("bp_drain3_valid", bus.res_valid_o, 1);
    tick();
    check("bp_empty", bus.res_valid_o, 0);
    check("bp_count", bus.op_count_o, 6);

    // Overflow sticky: set, set-beats-clear, clear alone
    req(8'h7F, 8'h01, 2'd0);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    check("ovf_res", bus.res_o, 8'h80);
    check("ovf_flags", bus.res_flags_o, 4'b0110);
    check("ovf_sticky_pre", bus.ovf_sticky_o, 0);
    tick();
    check("ovf_sticky_set", bus.ovf_sticky_o, 1);
    req(8'h7F, 8'h01, 2'd0);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.clr_sticky_i = 1'b1;
    tick();
    check("ovf_set_wins", bus.ovf_sticky_o, 1);
    tick();
    bus.clr_sticky_i = 1'b0;
    check("ovf_clear", bus.ovf_sticky_o, 0);
    check("ovf_count", bus.op_count_o, 8);

    // Flag bit 0 handling
    req(8'h05, 8'h05, 2'd1);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    check("zf_res", bus.res_o, 8'h00);
`ifdef ALU_EXEC_ZERO_FLAG_EN
    check("zf_flag0_zero", bus.res_flags_o[0], 1);
`else
    check("zf_flag0_zero", bus.res_flags_o[0], 0);
`endif
    tick();
    o_drive = 1'b1;
    req(8'h01, 8'h01, 2'd0);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    check("zf_res_nz", bus.res_o, 8'h02);
`ifdef ALU_EXEC_ZERO_FLAG_EN
    check("zf_flag0_nz", bus.res_flags_o[0], 0);
`else
    check("zf_flag0_nz", bus.res_flags_o[0], 1);
`endif
    tick();
    o_drive = 1'b0;
    check("zf_count", bus.op_count_o, 10);

    // Counter saturation after 17 more consumes (27 total)
    for (int i = 0; i < 17; i++) begin
      req(8'(i), 8'h01, 2'd3);
      tick();
    end
    bus.req_valid_i = 1'b0;
    check("sat_last_res", bus.res_o, 8'h07);
    tick(); tick();
    check("sat_count", bus.op_count_o, 4'hF);
    check("sat_empty", bus.res_valid_o, 0);

    // Reset with two ops pending
    bus.res_ready_i = 1'b0;
    req(8'h09, 8'h09, 2'd0);
    tick();
    req(8'h08, 8'h08, 2'd0);
    tick();
    bus.req_valid_i = 1'b0;
    check("mid_full", bus.req_ready_o, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_res_valid", bus.res_valid_o, 0);
    check("mid_req_ready", bus.req_ready_o, 1);
    check("mid_count", bus.op_count_o, 0);
    check("mid_res", bus.res_o, 0);
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_stale", bus.res_valid_o, 0);
    end
    check("mid_count_after", bus.op_count_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
